// File: rtl/mb32_booth_enc_load.sv
// rtl/mb32_booth_enc_load.sv - radix-8 Booth recoder and operand loader, two registered stages.
// Define MBENC_UNSIGNED_EN to treat x and y as unsigned (zero-extended) instead of two's complement.
module mb32_booth_enc_load #(
    parameter int WIDTH     = 32,
    parameter int GROUP_CNT = (WIDTH >> 2) + 3
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [GROUP_CNT-1:0] s,
    output logic [GROUP_CNT-1:0] d,
    output logic [GROUP_CNT-1:0] t,
    output logic [GROUP_CNT-1:0] q,
    output logic [GROUP_CNT-1:0] n,
    output logic [WIDTH-1:0]     my,
    output logic [WIDTH+1:0]     tmy,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam int XW = 3 * GROUP_CNT + 1;

    logic               a_valid;
    logic [WIDTH-1:0]   a_x;
    logic [WIDTH-1:0]   a_y;
    logic [WIDTH+1:0]   a_tmy;

    logic               b_load;
    logic               a_load;
    logic               x_ext;
    logic               y_ext;
    logic [WIDTH+1:0]   y_wide;
    logic [WIDTH+1:0]   tmy_next;
    logic [2*WIDTH:0]   x_wide;
    logic [XW-1:0]      xe;
    logic [3:0]         grp;
    logic [GROUP_CNT-1:0] rec_s, rec_d, rec_t, rec_q, rec_n;

    assign b_load   = !out_valid || out_ready;
    assign a_load   = !a_valid || b_load;
    assign in_ready = a_load;

`ifdef MBENC_UNSIGNED_EN
    assign y_ext = 1'b0;
    assign x_ext = 1'b0;
`else
    assign y_ext = y[WIDTH-1];
    assign x_ext = a_x[WIDTH-1];
`endif

    assign y_wide   = {{2{y_ext}}, y};
    assign tmy_next = y_wide + {y_wide[WIDTH:0], 1'b0};

    // x[-1] = 0 sits at bit 0, so group i is the 4-bit window xe[3i+3:3i].
    assign x_wide = {{WIDTH{x_ext}}, a_x, 1'b0};
    assign xe     = x_wide[XW-1:0];

    always_comb begin
        rec_s = '0;
        rec_d = '0;
        rec_t = '0;
        rec_q = '0;
        rec_n = '0;
        grp   = '0;
        for (int i = 0; i < GROUP_CNT; i++) begin
            grp = xe[3*i +: 4];
            case (grp)
                4'b0001, 4'b0010: rec_s[i] = 1'b1;
                4'b0011, 4'b0100: rec_d[i] = 1'b1;
                4'b0101, 4'b0110: rec_t[i] = 1'b1;
                4'b0111:          rec_q[i] = 1'b1;
                4'b1000: begin rec_q[i] = 1'b1; rec_n[i] = 1'b1; end
                4'b1001, 4'b1010: begin rec_t[i] = 1'b1; rec_n[i] = 1'b1; end
                4'b1011, 4'b1100: begin rec_d[i] = 1'b1; rec_n[i] = 1'b1; end
                4'b1101, 4'b1110: begin rec_s[i] = 1'b1; rec_n[i] = 1'b1; end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            a_valid <= 1'b0;
            a_x     <= '0;
            a_y     <= '0;
            a_tmy   <= '0;
        end else if (a_load) begin
            a_valid <= in_valid;
            if (in_valid) begin
                a_x   <= x;
                a_y   <= y;
                a_tmy <= tmy_next;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            out_valid <= 1'b0;
            s         <= '0;
            d         <= '0;
            t         <= '0;
            q         <= '0;
            n         <= '0;
            my        <= '0;
            tmy       <= '0;
        end else if (b_load) begin
            out_valid <= a_valid;
            if (a_valid) begin
                s   <= rec_s;
                d   <= rec_d;
                t   <= rec_t;
                q   <= rec_q;
                n   <= rec_n;
                my  <= a_y;
                tmy <= a_tmy;
            end
        end
    end

endmodule

// File: tb/tb_mb32_booth_enc_load.sv
// tb/tb_mb32_booth_enc_load.sv - scoreboard bench for mb32_booth_enc_load, both MBENC_UNSIGNED_EN builds.
module tb_mb32_booth_enc_load;

    localparam int W = 32;
    localparam int G = 11;

    logic          CLK = 1'b0;
    logic          RST;
    logic [W-1:0]  x, y;
    logic          in_valid, in_ready, out_valid, out_ready;
    logic [G-1:0]  s, d, t, q, n;
    logic [W-1:0]  my;
    logic [W+1:0]  tmy;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [W-1:0] x;
        logic [G-1:0] s, d, t, q, n;
        logic [W-1:0] my;
        logic [W+1:0] tmy;
    } exp_t;

    exp_t sb[$];
    exp_t e_pop;
    logic stall_prev = 1'b0;
    logic [5*G+W+W+1:0] held;

    mb32_booth_enc_load dut (
        .CLK(CLK), .RST(RST), .x(x), .y(y),
        .in_valid(in_valid), .in_ready(in_ready),
        .s(s), .d(d), .t(t), .q(q), .n(n),
        .my(my), .tmy(tmy),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 CLK = ~CLK;

    function automatic exp_t model(input logic [W-1:0] xi, input logic [W-1:0] yi);
        exp_t e;
        logic [W+3:0] xe;
        logic [W+1:0] ye;
        int dg;
        e = '0;
        e.x = xi;
        e.my = yi;
`ifdef MBENC_UNSIGNED_EN
        xe = {3'b000, xi, 1'b0};
        ye = {2'b00, yi};
`else
        xe = {{3{xi[W-1]}}, xi, 1'b0};
        ye = {{2{yi[W-1]}}, yi};
`endif
        e.tmy = ye * 34'd3;
        for (int i = 0; i < G; i++) begin
            dg = -4 * int'(xe[3*i+3]) + 2 * int'(xe[3*i+2]) + int'(xe[3*i+1]) + int'(xe[3*i]);
            if (dg < 0) begin
                e.n[i] = 1'b1;
                dg = -dg;
            end
            case (dg)
                1: e.s[i] = 1'b1;
                2: e.d[i] = 1'b1;
                3: e.t[i] = 1'b1;
                4: e.q[i] = 1'b1;
                default: ;
            endcase
        end
        return e;
    endfunction

    function automatic longint dut_sum();
        longint sum, dg;
        sum = 0;
        for (int i = 0; i < G; i++) begin
            dg = s[i] ? 1 : d[i] ? 2 : t[i] ? 3 : q[i] ? 4 : 0;
            if (n[i]) dg = -dg;
            sum += dg * (longint'(1) << (3 * i));
        end
        return sum;
    endfunction

    function automatic longint x_value(input logic [W-1:0] xi);
`ifdef MBENC_UNSIGNED_EN
        return longint'({32'b0, xi});
`else
        return longint'($signed(xi));
`endif
    endfunction

    function automatic logic groups_ok();
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < G; i++) begin
            if ($countones({s[i], d[i], t[i], q[i]}) > 1) ok = 1'b0;
            if (n[i] && !(s[i] | d[i] | t[i] | q[i])) ok = 1'b0;
        end
        return ok;
    endfunction

    always @(negedge CLK) begin
        if (!RST) begin
            sb.delete();
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                checks++;
                if ({s, d, t, q, n, my, tmy} !== held) begin
                    errors++;
                    $display("FAIL stall_hold got %h want %h", {s, d, t, q, n, my, tmy}, held);
                end
            end
            if (in_valid && in_ready) sb.push_back(model(x, y));
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_underflow got unexpected output my=%h want none", my);
                end else begin
                    e_pop = sb.pop_front();
                    if ({s, d, t, q, n, my, tmy} !== {e_pop.s, e_pop.d, e_pop.t, e_pop.q, e_pop.n, e_pop.my, e_pop.tmy}) begin
                        errors++;
                        $display("FAIL sb_data x=%h got s=%h d=%h t=%h q=%h n=%h my=%h tmy=%h want s=%h d=%h t=%h q=%h n=%h my=%h tmy=%h",
                                 e_pop.x, s, d, t, q, n, my, tmy,
                                 e_pop.s, e_pop.d, e_pop.t, e_pop.q, e_pop.n, e_pop.my, e_pop.tmy);
                    end
                    checks++;
                    if (dut_sum() != x_value(e_pop.x)) begin
                        errors++;
                        $display("FAIL digit_sum got %0d want %0d", dut_sum(), x_value(e_pop.x));
                    end
                    checks++;
                    if (!groups_ok()) begin
                        errors++;
                        $display("FAIL group_onehot got s=%h d=%h t=%h q=%h n=%h want one-hot", s, d, t, q, n);
                    end
                end
            end
            stall_prev = out_valid && !out_ready;
            held = {s, d, t, q, n, my, tmy};
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [W-1:0] xi, input logic [W-1:0] yi);
        int b;
        logic done;
        in_valid = 1'b1;
        x = xi;
        y = yi;
        b = 0;
        done = 1'b0;
        while (!done) begin
            @(negedge CLK);
            done = in_ready;
            step();
            b++;
            if (!done && b > 50) begin
                checks++;
                errors++;
                $display("FAIL send_timeout got in_ready=0 want 1 within 50 cycles");
                done = 1'b1;
            end
        end
    endtask

    task automatic drain();
        int b;
        out_ready = 1'b1;
        in_valid = 1'b0;
        b = 0;
        while ((sb.size() != 0 || out_valid) && b < 100) begin
            step();
            b++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", sb.size());
        end
    endtask

    task automatic test_reset();
        RST = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        x = '0;
        y = '0;
        step();
        step();
        RST = 1'b1;
        step();
        send(32'd11, 32'd1);
        send(32'd22, 32'd2);
        @(posedge CLK);
        #3;
        RST = 1'b0;
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_async got out_valid=%b want 0", out_valid);
        end
        step();
        step();
        @(negedge CLK);
        RST = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release got out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
        end
        checks++;
        if ({s, d, t, q, n, my, tmy} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got %h want 0", {s, d, t, q, n, my, tmy});
        end
        out_ready = 1'b1;
        step();
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        send(32'd7, 32'd5);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_latency got out_valid=%b want 0 one cycle after accept", out_valid);
        end
        step();
        checks++;
        if (out_valid !== 1'b1 || s !== 11'b00000000011 || n !== 11'b00000000001 ||
            d !== '0 || t !== '0 || q !== '0 || my !== 32'd5 || tmy !== 34'd15) begin
            errors++;
            $display("FAIL basic_x7 got v=%b s=%h n=%h d=%h t=%h q=%h my=%h tmy=%h want v=1 s=003 n=001 d=t=q=0 my=5 tmy=f",
                     out_valid, s, n, d, t, q, my, tmy);
        end
        step();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        send(32'd4, 32'd9);
        send(32'd3, 32'd10);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || q !== 11'd1 || n !== 11'd1 || s !== 11'd2 || d !== '0 || t !== '0) begin
            errors++;
            $display("FAIL b2b_first got v=%b s=%h d=%h t=%h q=%h n=%h want v=1 s=002 d=0 t=0 q=001 n=001",
                     out_valid, s, d, t, q, n);
        end
        step();
        checks++;
        if (out_valid !== 1'b1 || t !== 11'd1 || s !== '0 || d !== '0 || q !== '0 || n !== '0 || tmy !== 34'd30) begin
            errors++;
            $display("FAIL b2b_second got v=%b s=%h d=%h t=%h q=%h n=%h tmy=%h want v=1 t=001 rest 0 tmy=1e",
                     out_valid, s, d, t, q, n, tmy);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end got out_valid=%b want 0", out_valid);
        end
    endtask

`ifdef MBENC_UNSIGNED_EN
    task automatic test_unsigned();
        out_ready = 1'b1;
        send(32'hFFFFFFFF, 32'hFFFFFFFF);
        in_valid = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b1 || s !== 11'h001 || n !== 11'h001 || q !== 11'h400 ||
            d !== '0 || t !== '0 || tmy !== 34'h2FFFFFFFD) begin
            errors++;
            $display("FAIL unsigned_max got v=%b s=%h d=%h t=%h q=%h n=%h tmy=%h want v=1 s=001 d=0 t=0 q=400 n=001 tmy=2fffffffd",
                     out_valid, s, d, t, q, n, tmy);
        end
        step();
    endtask
`else
    task automatic test_negative();
        out_ready = 1'b1;
        send(32'hFFFFFFFF, 32'hFFFFFFFE);
        in_valid = 1'b0;
        step();
        checks++;
        if (out_valid !== 1'b1 || s !== 11'h001 || n !== 11'h001 || d !== '0 || t !== '0 || q !== '0 ||
            my !== 32'hFFFFFFFE || tmy !== 34'h3FFFFFFFA) begin
            errors++;
            $display("FAIL negative got v=%b s=%h d=%h t=%h q=%h n=%h my=%h tmy=%h want v=1 s=001 n=001 d=t=q=0 my=fffffffe tmy=3fffffffa",
                     out_valid, s, d, t, q, n, my, tmy);
        end
        step();
    endtask
`endif

    task automatic test_backpressure();
        logic [W-1:0] vals [4];
        int idx;
        int b;
        vals[0] = 32'h12345678;
        vals[1] = 32'h80000000;
        vals[2] = 32'h7FFFFFFF;
        vals[3] = 32'hDEADBEEF;
        out_ready = 1'b0;
        idx = 0;
        in_valid = 1'b1;
        x = vals[0];
        y = ~vals[0];
        for (int c = 0; c < 5; c++) begin
            @(negedge CLK);
            if (in_ready) idx++;
            step();
            if (idx < 4) begin
                x = vals[idx];
                y = ~vals[idx];
            end
        end
        checks++;
        if (idx != 2 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_accept got accepted=%0d in_ready=%b want 2 0", idx, in_ready);
        end
        out_ready = 1'b1;
        b = 0;
        while (idx < 4 && b < 50) begin
            @(negedge CLK);
            if (in_ready) idx++;
            step();
            b++;
            if (idx < 4) begin
                x = vals[idx];
                y = ~vals[idx];
            end
        end
        in_valid = 1'b0;
        drain();
    endtask

    task automatic test_random();
        int sent;
        int b;
        logic fired;
        sent = 0;
        b = 0;
        fired = 1'b1;
        in_valid = 1'b0;
        while (sent < 10000 && b < 60000) begin
            if (!in_valid || fired) begin
                in_valid = ($urandom_range(0, 4) != 0);
                case ($urandom_range(0, 7))
                    0: x = 32'h80000000;
                    1: x = 32'h7FFFFFFF;
                    2: x = 32'hFFFFFFFF;
                    3: x = 32'h00000000;
                    default: x = $urandom;
                endcase
                y = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
            end
            out_ready = ($urandom_range(0, 4) != 0);
            @(negedge CLK);
            fired = in_valid && in_ready;
            if (fired) sent++;
            step();
            b++;
        end
        checks++;
        if (sent != 10000) begin
            errors++;
            $display("FAIL random_sent got %0d want 10000", sent);
        end
        drain();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout got no finish want finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
`ifdef MBENC_UNSIGNED_EN
        test_unsigned();
`else
        test_negative();
`endif
        test_backpressure();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
